ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH SHALL default to 8; it is the RAM word-address width.
REQ-002 Parameter DATA_WIDTH SHALL default to 32; it is the RAM data width.
REQ-003 Parameter MAX_HOLD SHALL default to 4; it is the maximum number of consecutive locked grants to one requester while the other requester is waiting.
REQ-004 The block SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-005 Ports (name  direction  width  meaning):
 clk  in  1  clock
 rst  in  1  synchronous active-high reset
 rN_req  in  1  requester N access request (N = 0, 1)
 rN_we  in  1  requester N write (1) / read (0)
 rN_lock  in  1  requester N asks to keep ownership after this access
 rN_addr  in  ADDR_WIDTH  requester N word address
 rN_wdata  in  DATA_WIDTH  requester N write data
 rN_gnt  out  1  access of requester N performed this cycle
 rN_rvalid  out  1  read data valid for requester N
 rN_rdata  out  DATA_WIDTH  read data for requester N
 mem_en  out  1  RAM port enable
 mem_we  out  1  RAM port write enable
 mem_addr  out  ADDR_WIDTH  RAM port address
 mem_wdata  out  DATA_WIDTH  RAM port write data
 mem_rdata  in  DATA_WIDTH  RAM port read data (combinational from mem_addr)

Function
REQ-006 The block SHALL share one dual-port RAM port between requesters 0 and 1, with at most one grant per cycle.
REQ-007 Ownership states SHALL be IDLE, OWN0 and OWN1; the block SHALL also keep a last_gnt pointer and a hold_cnt counter (width clog2(MAX_HOLD)+1).
REQ-008 Grant selection SHALL be combinational within the cycle:
 - in OWNx with rx_req=1, grant x;
 - otherwise, if only one requester asserts req, grant that requester;
 - otherwise, if both assert req, grant the requester not equal to last_gnt.
REQ-009 rN_gnt SHALL be 1 only in a cycle where requester N is granted.
REQ-010 mem_en SHALL equal the OR of both gnt signals.
REQ-011 mem_we, mem_addr and mem_wdata SHALL equal the granted requester's we/addr/wdata, and all zeros when no grant.
REQ-012 A granted write SHALL commit at the clock edge ending the grant cycle.
REQ-013 After a granted read, rN_rvalid SHALL be 1 for exactly the next cycle, with rN_rdata equal to mem_rdata sampled at the grant edge (read latency 1).
REQ-014 rN_rdata SHALL hold its value when rN_rvalid=0; writes SHALL NOT produce rvalid.
REQ-015 On every grant to x, last_gnt SHALL become x.
REQ-016 State transitions after a grant to x:
 - if rx_lock=0: next state IDLE, hold_cnt=0;
 - if rx_lock=1 and the other requester is not requesting: OWNx, hold_cnt = min(hold_cnt+1, MAX_HOLD);
 - if rx_lock=1 and the other requester is requesting: OWNx with hold_cnt+1 while hold_cnt+1 < MAX_HOLD, else forced release to IDLE with hold_cnt=0.
REQ-017 If there is no grant in a cycle, the next state SHALL be IDLE and hold_cnt SHALL be 0.
REQ-018 In OWNx with rx_req=0, the other requester SHALL be granted in the same cycle if requesting (owner drop costs no bubble).
REQ-019 Simultaneous first requests after reset SHALL be granted to requester 0.
REQ-020 Under continuous requests from both without lock, grants SHALL strictly alternate.

Reset
REQ-021 While rst=1, all gnt outputs and mem_en, mem_we, mem_addr and mem_wdata SHALL be 0.
REQ-022 On a clock edge with rst=1: state IDLE, last_gnt=1, hold_cnt=0, r0/r1_rvalid=0, r0/r1_rdata=0.
REQ-023 Reset asserted in the cycle after a granted read SHALL suppress that read's rvalid.
REQ-024 Reset SHALL cancel any lock ownership.

Verification
REQ-025 After reset, r0 and r1 both read continuously with lock=0 -> gnt sequence 0,1,0,1; each rvalid one cycle after its gnt, with correct data.
REQ-026 r0 writes 0xDEADBEEF to address 0x10, then r1 reads 0x10 -> r1_rvalid with r1_rdata=0xDEADBEEF.
REQ-027 r0 requests with lock=1 for 10 cycles while r1 requests continuously -> r0 granted 4 cycles, r1 granted 1 cycle, then r0 granted 4 more, and so on.
REQ-028 r0 requests with lock=1 and r1 idle -> r0 granted every cycle indefinitely, with hold_cnt saturating at 4.
REQ-029 r0 in OWN0 drops req while r1 requests -> r1_gnt in that same cycle; mem_addr equals r1_addr.
REQ-030 r1 read granted, rst asserted in the next cycle -> r1_rvalid=0 and r1_rdata=0; the first request after reset is served normally.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter sharing a single RAM port, with lock-based ownership
// bounded by MAX_HOLD while the other requester waits.
module ram_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_HOLD   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  r0_req,
    input  logic                  r0_we,
    input  logic                  r0_lock,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_gnt,
    output logic                  r0_rvalid,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    input  logic                  r1_req,
    input  logic                  r1_we,
    input  logic                  r1_lock,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_gnt,
    output logic                  r1_rvalid,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned HOLD_W = $clog2(MAX_HOLD) + 1;
    localparam int unsigned INC_W  = HOLD_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                last_gnt_q;
    logic                last_gnt_d;
    logic [HOLD_W-1:0]   hold_q;
    logic [HOLD_W-1:0]   hold_d;
    logic                rvalid0_q;
    logic                rvalid1_q;
    logic [DATA_WIDTH-1:0] rdata0_q;
    logic [DATA_WIDTH-1:0] rdata1_q;

    logic              g0;
    logic              g1;
    logic              gnt_lock;
    logic              other_req;
    state_t            own_state;
    logic [INC_W-1:0]  hold_inc;

    // Grant selection: owner first, then single requester, then round-robin.
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (!rst) begin
            if (state_q == OWN0 && r0_req) begin
                g0 = 1'b1;
            end else if (state_q == OWN1 && r1_req) begin
                g1 = 1'b1;
            end else if (r0_req && !r1_req) begin
                g0 = 1'b1;
            end else if (r1_req && !r0_req) begin
                g1 = 1'b1;
            end else if (r0_req && r1_req) begin
                g0 = last_gnt_q;
                g1 = !last_gnt_q;
            end
        end
    end

    // Next ownership state and hold accounting.
    always_comb begin
        state_d    = IDLE;
        hold_d     = '0;
        last_gnt_d = last_gnt_q;
        gnt_lock   = g0 ? r0_lock : r1_lock;
        other_req  = g0 ? r1_req : r0_req;
        own_state  = g0 ? OWN0 : OWN1;
        hold_inc   = INC_W'({1'b0, hold_q}) + INC_W'(1);
        if (g0 || g1) begin
            last_gnt_d = g1;
            if (gnt_lock) begin
                if (!other_req) begin
                    state_d = own_state;
                    hold_d  = (hold_inc >= INC_W'(MAX_HOLD)) ? HOLD_W'(MAX_HOLD)
                                                              : HOLD_W'(hold_inc);
                end else if (hold_inc < INC_W'(MAX_HOLD)) begin
                    state_d = own_state;
                    hold_d  = HOLD_W'(hold_inc);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            hold_q     <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            hold_q     <= hold_d;
            rvalid0_q  <= g0 && !r0_we;
            rvalid1_q  <= g1 && !r1_we;
            if (g0 && !r0_we) begin
                rdata0_q <= mem_rdata;
            end
            if (g1 && !r1_we) begin
                rdata1_q <= mem_rdata;
            end
        end
    end

    // RAM port mux; zero when idle.
    always_comb begin
        mem_en    = g0 || g1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (g0) begin
            mem_we    = r0_we;
            mem_addr  = r0_addr;
            mem_wdata = r0_wdata;
        end else if (g1) begin
            mem_we    = r1_we;
            mem_addr  = r1_addr;
            mem_wdata = r1_wdata;
        end
    end

    // Reset in the cycle after a read must hide that read's response.
    assign r0_gnt    = g0;
    assign r1_gnt    = g1;
    assign r0_rvalid = rvalid0_q && !rst;
    assign r1_rvalid = rvalid1_q && !rst;
    assign r0_rdata  = rst ? '0 : rdata0_q;
    assign r1_rdata  = rst ? '0 : rdata1_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: RAM model, read-response scoreboard and
// per-scenario grant checks.
module tb_ram_port_arbiter;

    logic        clk;
    logic        rst;
    logic        r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
    logic [7:0]  r0_addr, r1_addr;
    logic [31:0] r0_wdata, r1_wdata;
    logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [31:0] r0_rdata, r1_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
    } sb_t;

    sb_t q0[$];
    sb_t q1[$];

    logic [31:0] ram     [256];
    logic [31:0] ref_mem [256];

    ram_port_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign mem_rdata = ram[mem_addr];

    always @(posedge clk) begin
        cyc++;
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    end

    function automatic logic [31:0] pat(input int a);
        return 32'h5A00_0000 ^ (32'(a) * 32'h0101_0103);
    endfunction

    function automatic sb_t mk(input int due, input logic [31:0] data);
        sb_t s;
        s.due  = due;
        s.data = data;
        return s;
    endfunction

    // Read-response scoreboard: each expected response is due one cycle after its grant.
    always @(negedge clk) begin
        sb_t e;
        total++;
        if (q0.size() > 0 && q0[0].due == cyc) begin
            e = q0.pop_front();
            if (r0_rvalid !== 1'b1 || r0_rdata !== e.data) begin
                bad++;
                $display("FAIL r0_read cyc=%0d got rvalid=%b data=%h want rvalid=1 data=%h",
                         cyc, r0_rvalid, r0_rdata, e.data);
            end
        end else if (r0_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL r0_rvalid_idle cyc=%0d got %b want 0", cyc, r0_rvalid);
        end
        total++;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            e = q1.pop_front();
            if (r1_rvalid !== 1'b1 || r1_rdata !== e.data) begin
                bad++;
                $display("FAIL r1_read cyc=%0d got rvalid=%b data=%h want rvalid=1 data=%h",
                         cyc, r1_rvalid, r1_rdata, e.data);
            end
        end else if (r1_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL r1_rvalid_idle cyc=%0d got %b want 0", cyc, r1_rvalid);
        end
    end

    task automatic set0(input logic req, input logic we, input logic lock,
                        input logic [7:0] a, input logic [31:0] d);
        r0_req = req; r0_we = we; r0_lock = lock; r0_addr = a; r0_wdata = d;
    endtask

    task automatic set1(input logic req, input logic we, input logic lock,
                        input logic [7:0] a, input logic [31:0] d);
        r1_req = req; r1_we = we; r1_lock = lock; r1_addr = a; r1_wdata = d;
    endtask

    task automatic idle_cycle(input string tag);
        @(posedge clk); #1;
        set0(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        set1(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        total++;
        if ({r0_gnt, r1_gnt, mem_en, mem_we} !== 4'b0000 || mem_addr !== 8'h00) begin
            bad++;
            $display("FAIL %s_idle got gnt=%b%b en=%b we=%b addr=%h want all zero",
                     tag, r0_gnt, r1_gnt, mem_en, mem_we, mem_addr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set0(1'b1, 1'b0, 1'b1, 8'h11, 32'h0);
        set1(1'b1, 1'b1, 1'b0, 8'h22, 32'h1234_5678);
        repeat (2) begin
            @(posedge clk); #1;
            @(negedge clk);
            total++;
            if ({r0_gnt, r1_gnt, mem_en, mem_we} !== 4'b0000) begin
                bad++;
                $display("FAIL reset_ctrl got gnt=%b%b en=%b we=%b want 0000",
                         r0_gnt, r1_gnt, mem_en, mem_we);
            end
            total++;
            if (mem_addr !== 8'h00 || mem_wdata !== 32'h0) begin
                bad++;
                $display("FAIL reset_bus got addr=%h wdata=%h want 0", mem_addr, mem_wdata);
            end
            total++;
            if (r0_rdata !== 32'h0 || r1_rdata !== 32'h0) begin
                bad++;
                $display("FAIL reset_rdata got %h %h want 0", r0_rdata, r1_rdata);
            end
            total++;
            if (dut.hold_q !== 3'd0) begin
                bad++;
                $display("FAIL reset_hold got %0d want 0", dut.hold_q);
            end
        end
    endtask

    task automatic test_alternate();
        logic       exp0;
        logic [7:0] ea;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            rst = 1'b0;
            set0(1'b1, 1'b0, 1'b0, 8'(i), 32'h0);
            set1(1'b1, 1'b0, 1'b0, 8'(8'h80 + i), 32'h0);
            exp0 = (i % 2 == 0);
            ea   = exp0 ? 8'(i) : 8'(8'h80 + i);
            if (exp0) q0.push_back(mk(cyc + 1, ref_mem[ea]));
            else      q1.push_back(mk(cyc + 1, ref_mem[ea]));
            @(negedge clk);
            total++;
            if ({r0_gnt, r1_gnt} !== {exp0, !exp0} || mem_en !== 1'b1) begin
                bad++;
                $display("FAIL alt_gnt i=%0d got gnt=%b%b en=%b want %b%b en=1",
                         i, r0_gnt, r1_gnt, mem_en, exp0, !exp0);
            end
            total++;
            if (mem_addr !== ea || mem_we !== 1'b0) begin
                bad++;
                $display("FAIL alt_addr i=%0d got addr=%h we=%b want %h we=0",
                         i, mem_addr, mem_we, ea);
            end
        end
        idle_cycle("alt");
    endtask

    task automatic test_write_read();
        @(posedge clk); #1;
        set0(1'b1, 1'b1, 1'b0, 8'h10, 32'hDEAD_BEEF);
        set1(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        total++;
        if ({r0_gnt, r1_gnt, mem_we} !== 3'b101 || mem_addr !== 8'h10 ||
            mem_wdata !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL wr_port got gnt=%b%b we=%b addr=%h wdata=%h want 10 1 10 deadbeef",
                     r0_gnt, r1_gnt, mem_we, mem_addr, mem_wdata);
        end
        ref_mem[8'h10] = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        set0(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        set1(1'b1, 1'b0, 1'b0, 8'h10, 32'h0);
        q1.push_back(mk(cyc + 1, ref_mem[8'h10]));
        @(negedge clk);
        total++;
        if ({r0_gnt, r1_gnt, mem_we} !== 3'b010 || mem_addr !== 8'h10) begin
            bad++;
            $display("FAIL rd_port got gnt=%b%b we=%b addr=%h want 01 0 10",
                     r0_gnt, r1_gnt, mem_we, mem_addr);
        end
        idle_cycle("wr");
        idle_cycle("wr2");
        total++;
        if (r1_rdata !== 32'hDEAD_BEEF || r1_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL rdata_hold got rvalid=%b data=%h want 0 deadbeef", r1_rvalid, r1_rdata);
        end
    endtask

    task automatic test_lock_hold();
        logic       exp1;
        logic [7:0] ea;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            set0(1'b1, 1'b0, 1'b1, 8'(8'h20 + i), 32'h0);
            set1(1'b1, 1'b0, 1'b0, 8'(8'h40 + i), 32'h0);
            exp1 = (i % 5 == 4);
            ea   = exp1 ? 8'(8'h40 + i) : 8'(8'h20 + i);
            if (exp1) q1.push_back(mk(cyc + 1, ref_mem[ea]));
            else      q0.push_back(mk(cyc + 1, ref_mem[ea]));
            @(negedge clk);
            total++;
            if ({r0_gnt, r1_gnt} !== {!exp1, exp1} || mem_addr !== ea) begin
                bad++;
                $display("FAIL lock_gnt i=%0d got gnt=%b%b addr=%h want %b%b addr=%h",
                         i, r0_gnt, r1_gnt, mem_addr, !exp1, exp1, ea);
            end
        end
        idle_cycle("lock");
    endtask

    task automatic test_lock_sat();
        int eh;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            set0(1'b1, 1'b0, 1'b1, 8'(8'h60 + i), 32'h0);
            set1(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
            q0.push_back(mk(cyc + 1, ref_mem[8'(8'h60 + i)]));
            eh = (i < 4) ? i : 4;
            @(negedge clk);
            total++;
            if ({r0_gnt, r1_gnt} !== 2'b10 || dut.hold_q !== 3'(eh)) begin
                bad++;
                $display("FAIL sat i=%0d got gnt=%b%b hold=%0d want 10 hold=%0d",
                         i, r0_gnt, r1_gnt, dut.hold_q, eh);
            end
        end
    endtask

    task automatic test_drop();
        @(posedge clk); #1;
        set0(1'b0, 1'b0, 1'b1, 8'h60, 32'h0);
        set1(1'b1, 1'b0, 1'b0, 8'h33, 32'h0);
        q1.push_back(mk(cyc + 1, ref_mem[8'h33]));
        @(negedge clk);
        total++;
        if ({r0_gnt, r1_gnt} !== 2'b01 || mem_addr !== 8'h33) begin
            bad++;
            $display("FAIL drop got gnt=%b%b addr=%h want 01 addr=33", r0_gnt, r1_gnt, mem_addr);
        end
        idle_cycle("drop");
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        set0(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        set1(1'b1, 1'b0, 1'b1, 8'h55, 32'h0);
        @(negedge clk);
        total++;
        if ({r0_gnt, r1_gnt} !== 2'b01) begin
            bad++;
            $display("FAIL rstmid_gnt got %b%b want 01", r0_gnt, r1_gnt);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        set1(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        total++;
        if (r1_rvalid !== 1'b0 || r1_rdata !== 32'h0) begin
            bad++;
            $display("FAIL rstmid_suppress got rvalid=%b data=%h want 0 0", r1_rvalid, r1_rdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        set0(1'b1, 1'b0, 1'b0, 8'h07, 32'h0);
        set1(1'b1, 1'b0, 1'b0, 8'h08, 32'h0);
        q0.push_back(mk(cyc + 1, ref_mem[8'h07]));
        @(negedge clk);
        total++;
        if ({r0_gnt, r1_gnt} !== 2'b10 || r1_rdata !== 32'h0 || mem_addr !== 8'h07) begin
            bad++;
            $display("FAIL rstmid_first got gnt=%b%b r1_rdata=%h addr=%h want 10 0 07",
                     r0_gnt, r1_gnt, r1_rdata, mem_addr);
        end
        @(posedge clk); #1;
        q1.push_back(mk(cyc + 1, ref_mem[8'h08]));
        @(negedge clk);
        total++;
        if ({r0_gnt, r1_gnt} !== 2'b01 || mem_addr !== 8'h08) begin
            bad++;
            $display("FAIL rstmid_second got gnt=%b%b addr=%h want 01 08", r0_gnt, r1_gnt, mem_addr);
        end
        idle_cycle("rstmid");
        idle_cycle("rstmid2");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     <= pat(i);
            ref_mem[i]  = pat(i);
        end
        rst = 1'b1;
        set0(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        set1(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        test_reset();
        test_alternate();
        test_write_read();
        test_lock_hold();
        test_lock_sat();
        test_drop();
        test_reset_mid();
        total++;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got pending=%0d/%0d want 0/0", q0.size(), q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
